// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types and line geometry for the cache-side AXI arbiter.
// Line alignment helper masks request addresses down to a line boundary.
package cache_axi_pkg;
    localparam int BEATS      = 8;
    localparam int LINE_BYTES = 32;
    localparam int CNT_W      = $clog2(BEATS);

    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA, R_DONE} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_DATA, W_DONE} wstate_e;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~32'(LINE_BYTES - 1);
    endfunction
endpackage

// File: rtl/cache_axi_arbiter_if.sv
// Cache-side requester and AXI-bridge signals of the arbiter, grouped as one bundle.
// slave = arbiter view, master = environment (caches + bridge) view.
interface cache_axi_arbiter_if;
    logic        ic_rreq;
    logic [31:0] ic_raddr;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        ic_rdone;
    logic        dc_rreq;
    logic [31:0] dc_raddr;
    logic [31:0] dc_rdata;
    logic        dc_rvalid;
    logic        dc_rdone;
    logic        dc_wreq;
    logic [31:0] dc_waddr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wsel;
    logic        dc_wnext;
    logic        dc_wdone;
    logic        axi_ce;
    logic        axi_ren;
    logic        axi_wen;
    logic [31:0] axi_raddr;
    logic [31:0] axi_waddr;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wsel;
    logic [7:0]  axi_rlen;
    logic [7:0]  axi_wlen;
    logic        axi_rready;
    logic        axi_wvalid;
    logic        axi_wlast;
    logic [31:0] axi_rdata;
    logic        axi_rdata_valid;
    logic        axi_wdata_resp;

    modport slave (
        input  ic_rreq, ic_raddr, dc_rreq, dc_raddr,
        input  dc_wreq, dc_waddr, dc_wdata, dc_wsel,
        input  axi_rdata, axi_rdata_valid, axi_wdata_resp,
        output ic_rdata, ic_rvalid, ic_rdone, dc_rdata, dc_rvalid, dc_rdone,
        output dc_wnext, dc_wdone,
        output axi_ce, axi_ren, axi_wen, axi_raddr, axi_waddr, axi_wdata, axi_wsel,
        output axi_rlen, axi_wlen, axi_rready, axi_wvalid, axi_wlast
    );

    modport master (
        output ic_rreq, ic_raddr, dc_rreq, dc_raddr,
        output dc_wreq, dc_waddr, dc_wdata, dc_wsel,
        output axi_rdata, axi_rdata_valid, axi_wdata_resp,
        input  ic_rdata, ic_rvalid, ic_rdone, dc_rdata, dc_rvalid, dc_rdone,
        input  dc_wnext, dc_wdone,
        input  axi_ce, axi_ren, axi_wen, axi_raddr, axi_waddr, axi_wdata, axi_wsel,
        input  axi_rlen, axi_wlen, axi_rready, axi_wvalid, axi_wlast
    );
endinterface

// File: rtl/cache_axi_arbiter_arb_rr2.sv
// Two-way refill arbiter, combinational grant; ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed priority DCache over ICache. No backpressure: caller decides when to take the grant.
module arb_rr2 import cache_axi_pkg::*; (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_advance,
`endif
    input  logic   i_req_ic,
    input  logic   i_req_dc,
    output logic   o_grant,
    output owner_e o_owner
);
    assign o_grant = i_req_ic | i_req_dc;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e r_last;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last <= OWN_IC;
        else if (i_advance)
            r_last <= o_owner;
    end

    // On a collision the requester not served last wins
    always_comb begin
        o_owner = OWN_IC;
        if (i_req_ic && i_req_dc)
            o_owner = (r_last == OWN_IC) ? OWN_DC : OWN_IC;
        else if (i_req_dc)
            o_owner = OWN_DC;
    end
`else
    assign o_owner = i_req_dc ? OWN_DC : OWN_IC;
`endif
endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares the AXI bridge cache port between ICache refill, DCache refill and DCache writeback;
// bursts are issue/data/done sequenced, refills to a line with a writeback in flight wait (ARB_ROUND_ROBIN_EN: RR arbitration).
module cache_axi_arbiter import cache_axi_pkg::*; (
    input logic                 clk,
    input logic                 rst,
    cache_axi_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    rstate_e          r_rstate, w_rstate_nxt;
    wstate_e          r_wstate, w_wstate_nxt;
    owner_e           r_owner;
    logic [31:0]      r_raddr;
    logic [31:0]      r_waddr;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] r_wcnt;

    logic   w_haz_ic, w_haz_dc;
    logic   w_req_ic, w_req_dc;
    logic   w_arb_grant;
    owner_e w_arb_owner;
    logic   w_take;
    logic   w_beat;
    logic   w_wbeat;

    // A refill may not overtake a writeback of the same line
    assign w_haz_ic = (r_wstate != W_IDLE) && (line_align(bus.ic_raddr) == r_waddr);
    assign w_haz_dc = (r_wstate != W_IDLE) && (line_align(bus.dc_raddr) == r_waddr);
    assign w_req_ic = bus.ic_rreq & ~w_haz_ic;
    assign w_req_dc = bus.dc_rreq & ~w_haz_dc;

    assign w_take  = (r_rstate == R_IDLE) && w_arb_grant;
    assign w_beat  = (r_rstate == R_DATA) && bus.axi_rdata_valid;
    assign w_wbeat = (r_wstate == W_DATA) && bus.axi_wdata_resp;

    arb_rr2 u_arb (
`ifdef ARB_ROUND_ROBIN_EN
        .i_clk     (clk),
        .i_rst     (rst),
        .i_advance (w_take),
`endif
        .i_req_ic  (w_req_ic),
        .i_req_dc  (w_req_dc),
        .o_grant   (w_arb_grant),
        .o_owner   (w_arb_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
            r_owner  <= OWN_IC;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_rcnt   <= '0;
            r_wcnt   <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
            if (w_take) begin
                r_owner <= w_arb_owner;
                r_raddr <= line_align((w_arb_owner == OWN_DC) ? bus.dc_raddr : bus.ic_raddr);
            end
            if (w_beat)
                r_rcnt <= (r_rcnt == CNT_LAST) ? '0 : r_rcnt + CNT_W'(1);
            // Latched on entry so the hazard compare is already valid during W_ISSUE
            if ((r_wstate == W_IDLE) && bus.dc_wreq)
                r_waddr <= line_align(bus.dc_waddr);
            if (w_wbeat)
                r_wcnt <= (r_wcnt == CNT_LAST) ? '0 : r_wcnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_rstate_nxt   = r_rstate;
        bus.ic_rdata   = '0;
        bus.ic_rvalid  = 1'b0;
        bus.ic_rdone   = 1'b0;
        bus.dc_rdata   = '0;
        bus.dc_rvalid  = 1'b0;
        bus.dc_rdone   = 1'b0;
        bus.axi_ren    = 1'b0;
        bus.axi_rready = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_arb_grant)
                    w_rstate_nxt = R_ISSUE;
            end
            R_ISSUE: begin
                bus.axi_ren  = 1'b1;
                w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                bus.axi_rready = 1'b1;
                if (w_beat) begin
                    if (r_owner == OWN_DC) begin
                        bus.dc_rvalid = 1'b1;
                        bus.dc_rdata  = bus.axi_rdata;
                    end else begin
                        bus.ic_rvalid = 1'b1;
                        bus.ic_rdata  = bus.axi_rdata;
                    end
                    if (r_rcnt == CNT_LAST)
                        w_rstate_nxt = R_DONE;
                end
            end
            R_DONE: begin
                if (r_owner == OWN_DC)
                    bus.dc_rdone = 1'b1;
                else
                    bus.ic_rdone = 1'b1;
                w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wstate_nxt   = r_wstate;
        bus.dc_wnext   = 1'b0;
        bus.dc_wdone   = 1'b0;
        bus.axi_wen    = 1'b0;
        bus.axi_wvalid = 1'b0;
        bus.axi_wlast  = 1'b0;
        bus.axi_wdata  = '0;
        bus.axi_wsel   = '0;
        case (r_wstate)
            W_IDLE: begin
                if (bus.dc_wreq)
                    w_wstate_nxt = W_ISSUE;
            end
            W_ISSUE: begin
                bus.axi_wen  = 1'b1;
                w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                bus.axi_wvalid = 1'b1;
                bus.axi_wdata  = bus.dc_wdata;
                bus.axi_wsel   = bus.dc_wsel;
                bus.dc_wnext   = bus.axi_wdata_resp;
                bus.axi_wlast  = (r_wcnt == CNT_LAST);
                if (w_wbeat && (r_wcnt == CNT_LAST))
                    w_wstate_nxt = W_DONE;
            end
            W_DONE: begin
                bus.dc_wdone = 1'b1;
                w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign bus.axi_ce    = bus.axi_ren | bus.axi_wen;
    assign bus.axi_raddr = r_raddr;
    assign bus.axi_waddr = r_waddr;
    assign bus.axi_rlen  = 8'(BEATS - 1);
    assign bus.axi_wlen  = 8'(BEATS - 1);

    a_owner_holds_req: assert property (@(posedge clk) disable iff (rst)
        (r_rstate inside {R_ISSUE, R_DATA}) |->
            ((r_owner == OWN_DC) ? bus.dc_rreq : bus.ic_rreq));
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: refill vector table plus arbitration, hazard,
// writeback handshake and mid-burst reset sequences.
module tb_cache_axi_arbiter;
    import cache_axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cache_axi_arbiter_if bus();

    cache_axi_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ic_req;
        logic [31:0] ic_addr;
        logic        dc_req;
        logic [31:0] dc_addr;
        logic        exp_dc;
        logic [31:0] exp_raddr;
    } rvec_t;

    rvec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ren(output int cyc);
        cyc = 0;
        do begin
            tick();
            #1;
            cyc++;
        end while (!bus.axi_ren && cyc < 30);
        chk("ren_seen", bus.axi_ren, 1'b1);
    endtask

    // Entered at +2 of the R_ISSUE cycle; leaves at +2 of the cycle after rdone
    task automatic read_burst(input logic own_dc, input logic [31:0] base, input bit gappy);
        tick();
        for (int k = 0; k < BEATS; k++) begin
            if (gappy && k != 0) begin
                bus.axi_rdata_valid = 1'b0;
                #1;
                chk("gap_rvalid", {bus.ic_rvalid, bus.dc_rvalid}, 2'b00);
                tick();
            end
            bus.axi_rdata_valid = 1'b1;
            bus.axi_rdata       = base + 32'(k);
            #1;
            if (k == 0)
                chk("ren_pulse", {bus.axi_ren, bus.axi_rready}, 2'b01);
            chk("rvalid_own", own_dc ? bus.dc_rvalid : bus.ic_rvalid, 1'b1);
            chk("rdata_own", own_dc ? bus.dc_rdata : bus.ic_rdata, base + 32'(k));
            chk("other_quiet", own_dc ? {bus.ic_rvalid, bus.ic_rdone} : {bus.dc_rvalid, bus.dc_rdone}, 2'b00);
            chk("rdone_early", {bus.ic_rdone, bus.dc_rdone}, 2'b00);
            tick();
        end
        bus.axi_rdata_valid = 1'b0;
        bus.axi_rdata       = '0;
        #1;
        chk("rdone", {bus.ic_rdone, bus.dc_rdone}, own_dc ? 2'b01 : 2'b10);
        chk("rready_off", bus.axi_rready, 1'b0);
        if (own_dc) bus.dc_rreq = 1'b0;
        else        bus.ic_rreq = 1'b0;
        tick();
        #1;
        chk("rdone_pulse", {bus.ic_rdone, bus.dc_rdone}, 2'b00);
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] exp_waddr, input logic [31:0] w0);
        bus.dc_wreq  = 1'b1;
        bus.dc_waddr = addr;
        bus.dc_wdata = w0;
        bus.dc_wsel  = 4'hF;
        tick();
        #1;
        chk("wen_ce", {bus.axi_wen, bus.axi_ce}, 2'b11);
        chk("waddr", bus.axi_waddr, exp_waddr);
    endtask

    task automatic write_beats(input bit toggle, input bit no_ren, input logic [31:0] w0);
        int n = 0;
        int cyc = 0;
        int nexts = 0;
        int last_hits = 0;
        int errs = 0;
        int ren_hits = 0;
        logic resp;
        logic [31:0] exp_wd;
        exp_wd = w0;
        while (n < BEATS && cyc < 40) begin
            tick();
            bus.dc_wdata = exp_wd;
            resp = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.axi_wdata_resp = resp;
            #1;
            if (bus.dc_wnext !== resp) errs++;
            if (bus.axi_wvalid !== 1'b1 || bus.axi_wdata !== exp_wd || bus.axi_wsel !== 4'hF) errs++;
            if (bus.axi_wlast !== (n == BEATS - 1)) errs++;
            if (bus.dc_wnext === 1'b1) nexts++;
            if (bus.dc_wnext === 1'b1 && bus.axi_wlast === 1'b1) last_hits++;
            if (bus.axi_ren === 1'b1) ren_hits++;
            if (resp) begin
                n++;
                exp_wd = w0 + 32'(n);
            end
            cyc++;
        end
        tick();
        bus.axi_wdata_resp = 1'b0;
        #1;
        chk("wnext_count", nexts, 8);
        chk("wbeat_errs", errs, 0);
        chk("wlast_hits", last_hits, 1);
        chk("wdone", {bus.dc_wdone, bus.axi_wvalid}, 2'b10);
        if (bus.axi_ren === 1'b1) ren_hits++;
        bus.dc_wreq = 1'b0;
        tick();
        #1;
        chk("wdone_pulse", bus.dc_wdone, 1'b0);
        if (bus.axi_ren === 1'b1) ren_hits++;
        if (no_ren)
            chk("haz_hold", ren_hits, 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_strobes"}, {bus.ic_rvalid, bus.ic_rdone, bus.dc_rvalid, bus.dc_rdone,
                                bus.dc_wnext, bus.dc_wdone, bus.axi_ce, bus.axi_ren, bus.axi_wen,
                                bus.axi_rready, bus.axi_wvalid, bus.axi_wlast}, 12'h000);
        chk({tag, "_rdata"}, bus.ic_rdata | bus.dc_rdata, 32'h0);
        chk({tag, "_addr"}, bus.axi_raddr | bus.axi_waddr | bus.axi_wdata, 32'h0);
        chk({tag, "_wsel"}, bus.axi_wsel, 4'h0);
        chk({tag, "_len"}, {bus.axi_rlen, bus.axi_wlen}, 16'h0707);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic exp_second_dc;

        vecs[0] = '{1'b1, 32'h1C00_0014, 1'b0, 32'h0,         1'b0, 32'h1C00_0000};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_003F, 1'b1, 32'h0000_0020};
`ifdef ARB_ROUND_ROBIN_EN
        vecs[2] = '{1'b1, 32'h0000_0040, 1'b1, 32'h8000_001F, 1'b0, 32'h0000_0040};
`else
        vecs[2] = '{1'b1, 32'h0000_0040, 1'b1, 32'h8000_001F, 1'b1, 32'h8000_0000};
`endif
        vecs[3] = '{1'b1, 32'hFFFF_FFE5, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5660};
        vecs[4] = '{1'b1, 32'h7FFF_FFFF, 1'b0, 32'h0,         1'b0, 32'h7FFF_FFE0};

        bus.ic_rreq = 1'b0;  bus.ic_raddr = '0;
        bus.dc_rreq = 1'b0;  bus.dc_raddr = '0;
        bus.dc_wreq = 1'b0;  bus.dc_waddr = '0;
        bus.dc_wdata = '0;   bus.dc_wsel = '0;
        bus.axi_rdata = '0;  bus.axi_rdata_valid = 1'b0;
        bus.axi_wdata_resp = 1'b0;

        repeat (3) tick();
        #1;
        check_quiet("reset");
        rst = 1'b0;
        tick();

        // Refill vector table
        for (int i = 0; i < 5; i++) begin
            bus.ic_rreq  = vecs[i].ic_req;
            bus.ic_raddr = vecs[i].ic_addr;
            bus.dc_rreq  = vecs[i].dc_req;
            bus.dc_raddr = vecs[i].dc_addr;
            wait_ren(cyc);
            chk("vec_raddr", bus.axi_raddr, vecs[i].exp_raddr);
            chk("vec_ce", bus.axi_ce, 1'b1);
            read_burst(vecs[i].exp_dc, 32'h0000_0100 * i, (i % 2) == 1);
            bus.ic_rreq = 1'b0;
            bus.dc_rreq = 1'b0;
        end

        // Collision, then DCache re-requests while ICache still waits
        bus.ic_rreq = 1'b1;  bus.ic_raddr = 32'h0000_0300;
        bus.dc_rreq = 1'b1;  bus.dc_raddr = 32'h0000_0400;
        wait_ren(cyc);
        chk("coll1_raddr", bus.axi_raddr, 32'h0000_0400);
        read_burst(1'b1, 32'hC000_0000, 1'b0);
        bus.dc_rreq = 1'b1;  bus.dc_raddr = 32'h0000_0500;
        wait_ren(cyc);
`ifdef ARB_ROUND_ROBIN_EN
        exp_second_dc = 1'b0;
        chk("coll2_raddr", bus.axi_raddr, 32'h0000_0300);
`else
        exp_second_dc = 1'b1;
        chk("coll2_raddr", bus.axi_raddr, 32'h0000_0500);
`endif
        read_burst(exp_second_dc, 32'hC100_0000, 1'b0);
        wait_ren(cyc);
        chk("coll3_raddr", bus.axi_raddr, exp_second_dc ? 32'h0000_0300 : 32'h0000_0500);
        read_burst(~exp_second_dc, 32'hC200_0000, 1'b0);

        // Same-line refill waits for the writeback to finish
        start_write(32'h0000_0100, 32'h0000_0100, 32'hD000_0000);
        bus.dc_rreq = 1'b1;  bus.dc_raddr = 32'h0000_0104;
        write_beats(1'b0, 1'b1, 32'hD000_0000);
        wait_ren(cyc);
        chk("haz_release", cyc, 1);
        chk("haz_raddr", bus.axi_raddr, 32'h0000_0100);
        read_burst(1'b1, 32'hA000_0000, 1'b0);

        // Different line overlaps the writeback
        start_write(32'h0000_011C, 32'h0000_0100, 32'hE000_0000);
        bus.dc_rreq = 1'b1;  bus.dc_raddr = 32'h0000_0200;
        wait_ren(cyc);
        chk("ovl_issue_cyc", cyc, 1);
        chk("ovl_raddr", bus.axi_raddr, 32'h0000_0200);
        chk("ovl_wvalid", bus.axi_wvalid, 1'b1);
        read_burst(1'b1, 32'hB000_0000, 1'b0);
        write_beats(1'b0, 1'b0, 32'hE000_0000);

        // Writeback with toggling response
        start_write(32'h0000_0547, 32'h0000_0540, 32'hF000_0000);
        write_beats(1'b1, 1'b1, 32'hF000_0000);

        // Reset during beat 3 of a refill
        bus.ic_rreq = 1'b1;  bus.ic_raddr = 32'h0000_0600;
        wait_ren(cyc);
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.axi_rdata_valid = 1'b1;
            bus.axi_rdata       = 32'h5500_0000 + 32'(k);
            tick();
        end
        bus.axi_rdata_valid = 1'b1;
        bus.axi_rdata       = 32'h5500_0003;
        rst         = 1'b1;
        bus.ic_rreq = 1'b0;
        tick();
        #1;
        check_quiet("midrst");
        bus.axi_rdata_valid = 1'b0;
        bus.axi_rdata       = '0;
        rst = 1'b0;
        tick();
        #1;
        chk("post_rst_rdone", {bus.ic_rdone, bus.dc_rdone, bus.axi_ren}, 3'b000);
        bus.ic_rreq = 1'b1;  bus.ic_raddr = 32'h1C00_0034;
        wait_ren(cyc);
        chk("fresh_raddr", bus.axi_raddr, 32'h1C00_0020);
        read_burst(1'b0, 32'h7700_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
